// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// MULTICYCLE_TRAP_EN adds the TRAP state and the trap-vector PC source.
package mc_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC, S_RTWB,
    S_BEQ, S_BNE, S_IMMEXEC, S_IMMWB, S_JUMP, S_JAL, S_JR
`ifdef MULTICYCLE_TRAP_EN
    , S_TRAP
`endif
  } mc_state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] F_JR  = 6'h08;
  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] PC_ALU    = 3'b000;
  localparam logic [2:0] PC_ALUOUT = 3'b001;
  localparam logic [2:0] PC_JUMP   = 3'b010;
  localparam logic [2:0] PC_REG    = 3'b011;
`ifdef MULTICYCLE_TRAP_EN
  localparam logic [2:0] PC_TRAP   = 3'b100;
`endif

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> instruction register / datapath / memory signal bundle.
interface multicycle_ctrl_if #(parameter int unsigned ALUCTL_W = 3);

  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                zero;
  logic                memready;
  logic                memreq;
  logic                memwrite;
  logic                iord;
  logic                irwrite;
  logic                regwrite;
  logic [1:0]          regdst;
  logic [1:0]          memtoreg;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic                immext;
  logic [2:0]          pcsrc;
  logic                pcen;
  logic [ALUCTL_W-1:0] alucontrol;
  logic                illegal;

  modport master (
    input  opcode, funct, zero, memready,
    output memreq, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, immext, pcsrc, pcen, alucontrol, illegal
  );

  modport slave (
    output opcode, funct, zero, memready,
    input  memreq, memwrite, iord, irwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, immext, pcsrc, pcen, alucontrol, illegal
  );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop and funct to an ALU code, zero-extended to ALUCTL_W.
module mc_aludec
  import mc_pkg::*;
#(
  parameter int unsigned ALUCTL_W = 3
) (
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [1:0]          aluop,
  output logic [ALUCTL_W-1:0] alucontrol_c
);

  logic [ALU_W-1:0] code;

  always_comb begin
    code = ALU_ADD;
    case (aluop)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unrecognised funct falls back to add rather than trapping.
        case (funct)
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_SLT:   code = ALU_SLT;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alucontrol_c = ALUCTL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready handshake and ALU decoder.
// Define MULTICYCLE_TRAP_EN to trap illegal opcodes (gated by TRAP_OPC_CHECK).
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned ALUCTL_W       = 3,
  parameter bit          TRAP_OPC_CHECK = 1'b1
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  mc_state_t          state, state_n;
  logic [1:0]         aluop;
  logic [FUNCT_W-1:0] alufunct;
  logic               memreq_c, memwrite_c, iord_c, irwrite_c, regwrite_c;
  logic [1:0]         regdst_c, memtoreg_c, alusrcb_c;
  logic               alusrca_c, immext_c, pcen_c, illegal_c;
  logic [2:0]         pcsrc_c;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    memreq_c   = 1'b0;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = REGDST_RT;
    memtoreg_c = MEMTOREG_ALU;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    immext_c   = 1'b0;
    pcsrc_c    = PC_ALU;
    pcen_c     = 1'b0;
    illegal_c  = 1'b0;
    aluop      = ALUOP_ADD;
    alufunct   = bus.funct;
    case (state)
      S_FETCH: begin
        memreq_c  = 1'b1;
        alusrcb_c = 2'b01;
        if (bus.memready) begin
          irwrite_c = 1'b1;
          pcen_c    = 1'b1;
          state_n   = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = (bus.funct == F_JR) ? S_JR : S_RTEXEC;
          OP_BEQ:       state_n = S_BEQ;
          OP_BNE:       state_n = S_BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_n = S_IMMEXEC;
          OP_J:         state_n = S_JUMP;
          OP_JAL:       state_n = S_JAL;
`ifdef MULTICYCLE_TRAP_EN
          default:      state_n = TRAP_OPC_CHECK ? S_TRAP : S_FETCH;
`else
          default:      state_n = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_n   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memreq_c = 1'b1;
        iord_c   = 1'b1;
        if (bus.memready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_c = MEMTOREG_MDR;
        regwrite_c = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWR: begin
        memreq_c   = 1'b1;
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.memready) state_n = S_FETCH;
      end
      S_RTEXEC: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_n   = S_RTWB;
      end
      S_RTWB: begin
        regdst_c   = REGDST_RD;
        regwrite_c = 1'b1;
        state_n    = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alusrca_c = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_c   = PC_ALUOUT;
        pcen_c    = (state == S_BEQ) ? bus.zero : !bus.zero;
        state_n   = S_FETCH;
      end
      S_IMMEXEC: begin
        // Immediate ops reuse the funct path of the ALU decoder.
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        aluop     = ALUOP_FUNCT;
        case (bus.opcode)
          OP_SLTI: alufunct = F_SLT;
          OP_ANDI: begin alufunct = F_AND; immext_c = 1'b1; end
          OP_ORI:  begin alufunct = F_OR;  immext_c = 1'b1; end
          default: alufunct = F_ADD;
        endcase
        state_n = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        state_n    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_c = PC_JUMP;
        pcen_c  = 1'b1;
        state_n = S_FETCH;
      end
      S_JAL: begin
        regdst_c   = REGDST_RA;
        memtoreg_c = MEMTOREG_PC;
        regwrite_c = 1'b1;
        pcsrc_c    = PC_JUMP;
        pcen_c     = 1'b1;
        state_n    = S_FETCH;
      end
      S_JR: begin
        pcsrc_c = PC_REG;
        pcen_c  = 1'b1;
        state_n = S_FETCH;
      end
`ifdef MULTICYCLE_TRAP_EN
      S_TRAP: begin
        illegal_c = 1'b1;
        pcsrc_c   = PC_TRAP;
        pcen_c    = 1'b1;
        state_n   = S_FETCH;
      end
`endif
      default: state_n = S_FETCH;
    endcase
    // Reset suppresses every side effect, including an in-flight store.
    if (reset) begin
      memreq_c   = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      pcen_c     = 1'b0;
      illegal_c  = 1'b0;
    end
  end

`ifndef MULTICYCLE_TRAP_EN
  logic unused_trap_cfg;
  assign unused_trap_cfg = TRAP_OPC_CHECK;
`endif

  mc_aludec #(.ALUCTL_W(ALUCTL_W)) u_aludec (
    .funct        (alufunct),
    .aluop        (aluop),
    .alucontrol_c (bus.alucontrol)
  );

  assign bus.memreq   = memreq_c;
  assign bus.memwrite = memwrite_c;
  assign bus.iord     = iord_c;
  assign bus.irwrite  = irwrite_c;
  assign bus.regwrite = regwrite_c;
  assign bus.regdst   = regdst_c;
  assign bus.memtoreg = memtoreg_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.immext   = immext_c;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.pcen     = pcen_c;
  assign bus.illegal  = illegal_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction control recipes
// compared cycle by cycle on a 3-bit and a 4-bit ALU-control instance.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       memreq, memwrite, iord, irwrite, regwrite;
    logic [1:0] regdst, memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immext;
    logic [2:0] pcsrc;
    logic       pcen;
    logic [2:0] alu;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t v;
    logic mem;
    logic fetch;
  } phase_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, memready;
  int         errors = 0;
  int         checks = 0;
  phase_t     plan[$];

  multicycle_ctrl_if #(.ALUCTL_W(3)) bus ();
  multicycle_ctrl_if #(.ALUCTL_W(4)) bus4 ();

  assign bus.opcode    = opcode;
  assign bus.funct     = funct;
  assign bus.zero      = zero;
  assign bus.memready  = memready;
  assign bus4.opcode   = opcode;
  assign bus4.funct    = funct;
  assign bus4.zero     = zero;
  assign bus4.memready = memready;

  multicycle_ctrl #(.ALUCTL_W(3)) dut  (.clk(clk), .reset(reset), .bus(bus));
  multicycle_ctrl #(.ALUCTL_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  ctl_t act, act4;
  logic act4_hi;
  assign act = {bus.memreq, bus.memwrite, bus.iord, bus.irwrite, bus.regwrite,
                bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.immext,
                bus.pcsrc, bus.pcen, bus.alucontrol, bus.illegal};
  assign act4 = {bus4.memreq, bus4.memwrite, bus4.iord, bus4.irwrite, bus4.regwrite,
                 bus4.regdst, bus4.memtoreg, bus4.alusrca, bus4.alusrcb, bus4.immext,
                 bus4.pcsrc, bus4.pcen, bus4.alucontrol[2:0], bus4.illegal};
  assign act4_hi = bus4.alucontrol[3];

  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.alu = 3'b010;
    return c;
  endfunction

  function automatic logic [2:0] rt_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic void push(input ctl_t c, input logic mem, input logic fetch);
    phase_t p;
    p.v = c; p.mem = mem; p.fetch = fetch;
    plan.push_back(p);
  endfunction

  // Expected control sequence of one instruction, phase by phase.
  function automatic void build_plan(input logic [5:0] op, input logic [5:0] fn,
                                     input logic z);
    ctl_t c;
    plan.delete();
    c = idle(); c.memreq = 1; c.alusrcb = 2'b01; c.irwrite = 1; c.pcen = 1;
    push(c, 1'b1, 1'b1);
    c = idle(); c.alusrcb = 2'b11;
    push(c, 1'b0, 1'b0);
    case (op)
      6'h23, 6'h2B: begin
        c = idle(); c.alusrca = 1; c.alusrcb = 2'b10;
        push(c, 1'b0, 1'b0);
        c = idle(); c.memreq = 1; c.iord = 1; c.memwrite = (op == 6'h2B);
        push(c, 1'b1, 1'b0);
        if (op == 6'h23) begin
          c = idle(); c.memtoreg = 2'b01; c.regwrite = 1;
          push(c, 1'b0, 1'b0);
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          c = idle(); c.pcsrc = 3'b011; c.pcen = 1;
          push(c, 1'b0, 1'b0);
        end else begin
          c = idle(); c.alusrca = 1; c.alu = rt_alu(fn);
          push(c, 1'b0, 1'b0);
          c = idle(); c.regdst = 2'b01; c.regwrite = 1;
          push(c, 1'b0, 1'b0);
        end
      end
      6'h04, 6'h05: begin
        c = idle(); c.alusrca = 1; c.alu = 3'b110; c.pcsrc = 3'b001;
        c.pcen = (op == 6'h04) ? z : !z;
        push(c, 1'b0, 1'b0);
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        c = idle(); c.alusrca = 1; c.alusrcb = 2'b10;
        c.alu = (op == 6'h0A) ? 3'b111 : (op == 6'h0C) ? 3'b000 :
                (op == 6'h0D) ? 3'b001 : 3'b010;
        c.immext = (op == 6'h0C) || (op == 6'h0D);
        push(c, 1'b0, 1'b0);
        c = idle(); c.regwrite = 1;
        push(c, 1'b0, 1'b0);
      end
      6'h02: begin
        c = idle(); c.pcsrc = 3'b010; c.pcen = 1;
        push(c, 1'b0, 1'b0);
      end
      6'h03: begin
        c = idle(); c.regdst = 2'b10; c.memtoreg = 2'b10; c.regwrite = 1;
        c.pcsrc = 3'b010; c.pcen = 1;
        push(c, 1'b0, 1'b0);
      end
      default: begin
`ifdef MULTICYCLE_TRAP_EN
        c = idle(); c.illegal = 1; c.pcsrc = 3'b100; c.pcen = 1;
        push(c, 1'b0, 1'b0);
`endif
      end
    endcase
  endfunction

  // Runs one instruction; stall < 0 picks 0..2 random stall cycles per access.
  task automatic drive_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fstall, input int mstall,
                             output int ncyc);
    build_plan(op, fn, z);
    opcode = op; funct = fn; zero = z; ncyc = 0;
    foreach (plan[i]) begin
      int stalls;
      stalls = 0;
      if (plan[i].mem) begin
        stalls = plan[i].fetch ? fstall : mstall;
        if (stalls < 0) stalls = int'($urandom_range(0, 2));
      end
      for (int s = 0; s <= stalls; s++) begin
        ctl_t e;
        e = plan[i].v;
        if (plan[i].mem) memready = (s == stalls);
        else             memready = 1'($urandom);
        if (plan[i].fetch && !memready) begin e.irwrite = 0; e.pcen = 0; end
        @(negedge clk);
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s ph%0d cyc%0d ctl: got %h want %h", tag, i, ncyc + 1, act, e);
        end
        checks++;
        if ({act4_hi, act4} !== {1'b0, e}) begin
          errors++;
          $display("FAIL %s ph%0d cyc%0d ctl_w4: got %h want %h", tag, i, ncyc + 1,
                   {act4_hi, act4}, {1'b0, e});
        end
        ncyc++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; memready = 1; opcode = 6'h2B; funct = 6'h00; zero = 0;
    #2;
    checks++;
    if ({bus.memreq, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pre_edge: got %b want 00000",
               {bus.memreq, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.memreq, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: got %b want 00000",
               {bus.memreq, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen});
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_lw();
    int n;
    drive_instr("lw", 6'h23, 6'h00, 1'b0, 0, 0, n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL lw_latency: got %0d want 5", n); end
  endtask

  task automatic test_sw_stall();
    int n;
    drive_instr("sw_stall", 6'h2B, 6'h00, 1'b0, 0, 3, n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL sw_stall_latency: got %0d want 7", n); end
  endtask

  task automatic test_branch();
    int n;
    for (int k = 0; k < 4; k++) begin
      drive_instr("branch", (k[0] ? 6'h05 : 6'h04), 6'h00, ~k[1], 0, 0, n);
      checks++;
      if (n !== 3) begin errors++; $display("FAIL branch_latency%0d: got %0d want 3", k, n); end
    end
  endtask

  task automatic test_jal_jr();
    int n;
    drive_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL jal_latency: got %0d want 3", n); end
    drive_instr("jr", 6'h00, 6'h08, 1'b0, 0, 0, n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL jr_latency: got %0d want 3", n); end
  endtask

  task automatic test_imm();
    logic [5:0] ops [4];
    int n;
    ops = '{6'h0D, 6'h0C, 6'h0A, 6'h08};
    foreach (ops[k]) begin
      drive_instr("imm", ops[k], 6'h00, 1'b0, 0, 0, n);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL imm_latency%0d: got %0d want 4", k, n); end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6];
    int n;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
    foreach (fns[k]) begin
      drive_instr("rtype", 6'h00, fns[k], 1'b0, 1, 0, n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL rtype_latency%0d: got %0d want 5", k, n); end
    end
  endtask

  task automatic test_illegal();
    int n;
    drive_instr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0, n);
`ifdef MULTICYCLE_TRAP_EN
    checks++;
    if (n !== 3) begin errors++; $display("FAIL illegal_latency: got %0d want 3", n); end
`else
    checks++;
    if (n !== 2) begin errors++; $display("FAIL illegal_latency: got %0d want 2", n); end
`endif
    memready = 0;
    @(negedge clk);
    checks++;
    if ({bus.memreq, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen, bus.illegal}
        !== 6'b100000) begin
      errors++;
      $display("FAIL illegal_refetch: got %b want 100000",
               {bus.memreq, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcen, bus.illegal});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store();
    opcode = 6'h2B; funct = 6'h00; memready = 1;
    repeat (3) begin @(posedge clk); #1; end
    memready = 0;
    @(negedge clk);
    checks++;
    if ({bus.memreq, bus.memwrite} !== 2'b11) begin
      errors++;
      $display("FAIL store_pending: got %b want 11", {bus.memreq, bus.memwrite});
    end
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    checks++;
    if ({bus.memreq, bus.memwrite, bus.pcen} !== 3'b000) begin
      errors++;
      $display("FAIL store_abort: got %b want 000", {bus.memreq, bus.memwrite, bus.pcen});
    end
    memready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.memreq, bus.memwrite, bus.irwrite, bus.pcen} !== 4'b0000) begin
      errors++;
      $display("FAIL store_abort_held: got %b want 0000",
               {bus.memreq, bus.memwrite, bus.irwrite, bus.pcen});
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [14];
    logic [5:0] fns [7];
    int n;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
            6'h23, 6'h2B, 6'h3F, 6'h11};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h01};
    for (int k = 0; k < 150; k++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 13)];
      fn = fns[$urandom_range(0, 6)];
      drive_instr("random", op, fn, 1'($urandom), -1, -1, n);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_jal_jr();
    test_imm();
    test_rtype();
    test_illegal();
    test_reset_mid_store();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Next-generation control unit for the multi-cycle MIPS core. It replaces the fixed-latency controller with an FSM plus ALU decoder that waits on a memory ready handshake and adds `bne`, `andi`, `ori`, `slti`, `jal` and `jr`. It also parametrises the ALU-control width and can trap illegal opcodes. It sits between the instruction register and the datapath, driving every mux select and write enable.

## Interface
Parameters:
- `ALUCTL_W`, default 3: width of `alucontrol`; must be ≥3, and upper bits are zero.
- `TRAP_OPC_CHECK`, default 1: when 0, the illegal-opcode check is disabled even if the trap macro is defined.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory completes the access this cycle.
- `memreq` out 1: memory access request.
- `memwrite` out 1: store strobe, only valid with `memreq`.
- `iord` out 1: 0 = PC address, 1 = ALUOut address.
- `irwrite` out 1: latch the instruction register.
- `regwrite` out 1: register file write.
- `regdst` out 2: 00 = rt, 01 = rd, 10 = $31.
- `memtoreg` out 2: 00 = ALUOut, 01 = MDR, 10 = PC (link).
- `alusrca` out 1: 0 = PC, 1 = A.
- `alusrcb` out 2: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `immext` out 1: 1 = zero-extend, 0 = sign-extend.
- `pcsrc` out 3: 000 = ALU, 001 = ALUOut, 010 = jump target, 011 = A (`jr`), 100 = trap vector.
- `pcen` out 1: PC write enable.
- `alucontrol` out `ALUCTL_W`: ALU operation.
- `illegal` out 1: trap indicator (macro only).

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RTWB, BEQ, BNE, IMMEXEC, IMMWB, JUMP, JAL, JR, TRAP.
- FETCH: `memreq` = 1, `iord` = 0, `alusrca` = 0, `alusrcb` = 01, ALU add, `pcsrc` = 000.
  - `irwrite` and `pcen` are asserted only in the cycle with `memready` = 1; the FSM then moves to DECODE.
  - Otherwise the FSM holds in FETCH with no writes.
- DECODE: `alusrcb` = 11, add; computes the branch target into ALUOut.
  - Dispatch on opcode: `lw`/`sw` → MEMADR; R-type → RTEXEC, or → JR when `funct` = 0x08; `beq` → BEQ; `bne` → BNE; `addi`/`andi`/`ori`/`slti` → IMMEXEC; `j` → JUMP; `jal` → JAL.
- MEMADR: `alusrca` = 1, `alusrcb` = 10, add. `lw` → MEMRD, `sw` → MEMWR.
- MEMRD: `memreq` = 1, `iord` = 1. Holds until `memready`, then → MEMWB.
- MEMWB: `regdst` = 00, `memtoreg` = 01, `regwrite` = 1.
- MEMWR: `memreq` = 1, `memwrite` = 1, `iord` = 1. Holds until `memready`.
- RTEXEC: `alusrca` = 1, `alusrcb` = 00; ALU op taken from `funct`.
- RTWB: `regdst` = 01, `regwrite` = 1.
- BEQ and BNE: subtract, `pcsrc` = 001.
  - BEQ: `pcen` = `zero`.
  - BNE: `pcen` = `!zero`.
- IMMEXEC: `alusrcb` = 10.
  - `addi`: add. `slti`: slt. `andi`: and, `immext` = 1. `ori`: or, `immext` = 1.
- IMMWB: `regdst` = 00, `memtoreg` = 00, `regwrite` = 1.
- JUMP: `pcsrc` = 010, `pcen` = 1.
- JAL: `regdst` = 10, `memtoreg` = 10, `regwrite` = 1, `pcsrc` = 010, `pcen` = 1. The link value is PC, already PC+4.
- JR: `pcsrc` = 011, `pcen` = 1.
- Every terminal state returns to FETCH.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
  - Unknown R-type `funct` yields add and no trap.

## Timing
- Next state is registered; all outputs are combinational from the current state plus `opcode`, `funct`, `zero` and `memready`.
- While `reset` = 1, all write enables and `memreq` are forced to 0. The first edge with `reset` high puts the FSM in FETCH; fetch starts in the first cycle after reset is released.
- Reset mid-access (e.g. in MEMWR): the store is abandoned and no `memwrite` is asserted during reset.
- Instruction latency with `memready` tied to 1:
  - `lw`: 5 cycles.
  - `sw`, R-type, immediate ops: 4 cycles.
  - branches, `j`, `jal`, `jr`: 3 cycles.
- Each memory stall cycle adds exactly one cycle. `memreq` remains high and the other outputs stay stable during a stall.
- `memready` outside a `memreq` cycle is ignored.

## Configuration
- `MULTICYCLE_TRAP_EN` defined and `TRAP_OPC_CHECK` = 1:
  - An unknown opcode in DECODE → TRAP.
  - TRAP asserts `illegal` = 1, `pcsrc` = 100 and `pcen` = 1 for one cycle, then → FETCH.
- Macro undefined: no TRAP state; an unknown opcode in DECODE → FETCH as a NOP, and `illegal` is tied to 0.

## Structure
- Package `mc_pkg`:
  - state enum `mc_state_t`;
  - opcode and funct constants;
  - ALU code constants;
  - `pcsrc`/`regdst`/`memtoreg` encodings.
- One sub-module, `mc_aludec`: a combinational map from `funct` and a 2-bit `aluop` to `alucontrol`, parametrised by `ALUCTL_W`.

## Test plan
- `reset` high for 2 cycles, then `lw` with `memready` = 1 → `regwrite` with `memtoreg` = 01 in cycle 5; `pcen` pulses once in FETCH.
- `sw` with `memready` low for 3 cycles in MEMWR → `memwrite`/`memreq` held 4 cycles; exactly one completing cycle.
- `beq`/`bne` with `zero` = 1 → `beq` gives `pcen` = 1 with `pcsrc` = 001; `bne` gives `pcen` = 0.
- `jal` (opcode 0x03) → cycle 3 shows `regdst` = 10, `memtoreg` = 10, `regwrite` = 1, `pcsrc` = 010; then `jr` (R-type, `funct` 0x08) gives `pcsrc` = 011.
- `ori` (0x0D) → `immext` = 1 and `alucontrol` = 001 in IMMEXEC; with `ALUCTL_W` = 4, `alucontrol` = 0001.
- Opcode 0x3F with the macro defined → `illegal` = 1, `pcsrc` = 100 in cycle 3. Without the macro → back in FETCH at cycle 3 with no writes.
